// File: rtl/lwe_pkg.sv
// Shared constants and helpers for the LWE encryption datapath.
// Holds the default parameter values used by every block in the slice and
// the modulus-reduction helper. All moduli are powers of two, so reduction
// is a plain mask of the low log2(modulus) bits.
package lwe_pkg;

    localparam int DEF_PLAINTEXT_MODULUS  = 64;
    localparam int DEF_PLAINTEXT_WIDTH    = 6;
    localparam int DEF_CIPHERTEXT_MODULUS = 1024;
    localparam int DEF_CIPHERTEXT_WIDTH   = 32;
    localparam int DEF_DIMENSION          = 3;
    localparam int DEF_DIM_WIDTH          = 2;
    localparam int DEF_BIG_N              = 2;
    localparam int DEF_PARALLEL           = 2;

    // Widest value the reduction helper accepts; callers zero-extend into it.
    localparam int MAX_W = 64;

    // Reduce a value modulo a power-of-two modulus by masking.
    function automatic logic [MAX_W-1:0] mod_reduce(
        input logic [MAX_W-1:0] value,
        input logic [MAX_W-1:0] modulus
    );
        return value & (modulus - {{(MAX_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/lane_sum.sv
// Combinational adder over 2*PARALLEL operand lanes.
// Produces partial = (sum op1[i] + sum op2[i]) mod MODULUS.
// Ports:
//   op1, op2 : PARALLEL lanes of WIDTH bits each
//   partial  : reduced per-cycle sum, WIDTH bits (upper bits always 0)
// The running sum is kept at full lane width; overflow past 2^WIDTH is
// harmless because the modulus is a power of two no larger than 2^WIDTH.
module lane_sum
    import lwe_pkg::*;
#(
    parameter int WIDTH    = DEF_CIPHERTEXT_WIDTH,
    parameter int MODULUS  = DEF_CIPHERTEXT_MODULUS,
    parameter int PARALLEL = DEF_PARALLEL
) (
    input  logic [WIDTH-1:0] op1 [PARALLEL],
    input  logic [WIDTH-1:0] op2 [PARALLEL],
    output logic [WIDTH-1:0] partial
);

    logic [WIDTH-1:0] total;

    // Sum every lane of both operand arrays; synthesis balances the chain.
    always_comb begin
        total = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            total = total + op1[i] + op2[i];
        end
    end

    // Reduce the full-width sum to the ciphertext modulus.
    always_comb begin
        partial = WIDTH'(mod_reduce(MAX_W'(total), MAX_W'(MODULUS)));
    end

endmodule

// File: rtl/lwe_encrypt_accum.sv
// Streaming row accumulator for the LWE encryption datapath.
// Each enabled cycle the lane sum P is added (mod CIPHERTEXT_MODULUS) into a
// running per-row total. When the row index changes on an enabled cycle, or
// done is pulsed, the finished total is registered onto ciphertext.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous reset, ACTIVE-HIGH despite its name
//   done       : flush pulse, publishes the current row total
//   en         : accumulate this cycle's lanes
//   op1, op2   : PARALLEL operand lanes of CIPHERTEXT_WIDTH bits
//   row        : row index of this cycle's operands (any value accepted)
//   ciphertext : registered total of the most recently completed row
// PLAINTEXT_*, DIMENSION and BIG_N are carried for interface uniformity with
// the rest of the datapath and do not enter the arithmetic.
module lwe_encrypt_accum
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
    parameter int PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
    parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
    parameter int DIMENSION          = DEF_DIMENSION,
    parameter int DIM_WIDTH          = DEF_DIM_WIDTH,
    parameter int BIG_N              = DEF_BIG_N,
    parameter int PARALLEL           = DEF_PARALLEL
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        done,
    input  logic                        en,
    input  logic [CIPHERTEXT_WIDTH-1:0] op1 [PARALLEL],
    input  logic [CIPHERTEXT_WIDTH-1:0] op2 [PARALLEL],
    input  logic [DIM_WIDTH-1:0]        row,
    output logic [CIPHERTEXT_WIDTH-1:0] ciphertext
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,   // no row in progress, acc is zero
        ST_ACCUM = 1'b1    // a row is being accumulated
    } acc_state_t;

    acc_state_t                  state, state_next;
    logic [CIPHERTEXT_WIDTH-1:0] acc, acc_next;
    logic [CIPHERTEXT_WIDTH-1:0] ct_next;
    logic [DIM_WIDTH-1:0]        last_row, last_row_next;
    logic [CIPHERTEXT_WIDTH-1:0] partial;
    logic [CIPHERTEXT_WIDTH-1:0] acc_plus_p;
    logic                        same_row;

    lane_sum #(
        .WIDTH    (CIPHERTEXT_WIDTH),
        .MODULUS  (CIPHERTEXT_MODULUS),
        .PARALLEL (PARALLEL)
    ) u_lane_sum (
        .op1     (op1),
        .op2     (op2),
        .partial (partial)
    );

    // Modular running sum and row-match flag used by the next-state logic.
    always_comb begin
        acc_plus_p = CIPHERTEXT_WIDTH'(mod_reduce(MAX_W'(acc) + MAX_W'(partial),
                                                  MAX_W'(CIPHERTEXT_MODULUS)));
        same_row   = (row == last_row);
    end

    // Next-state and publish decisions; done takes priority over row change.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        last_row_next = last_row;
        ct_next       = ciphertext;
        if (done) begin
            if (en && !same_row) begin
                // Publish the old row and open the new one with this cycle's P.
                ct_next       = acc;
                acc_next      = partial;
                last_row_next = row;
                state_next    = ST_ACCUM;
            end else begin
                if (en) begin
                    ct_next = acc_plus_p;
                end else if (state == ST_ACCUM) begin
                    ct_next = acc;
                end else begin
                    ct_next = '0;
                end
                acc_next   = '0;
                state_next = ST_IDLE;
            end
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    acc_next      = partial;
                    last_row_next = row;
                    state_next    = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (same_row) begin
                        acc_next = acc_plus_p;
                    end else begin
                        ct_next       = acc;
                        acc_next      = partial;
                        last_row_next = row;
                    end
                end
                default: begin
                    acc_next   = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end else begin
            // Disabled cycle: everything holds, row changes are ignored.
            state_next = state;
        end
    end

    // State, accumulator and published-output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            last_row   <= '0;
            ciphertext <= '0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            last_row   <= last_row_next;
            ciphertext <= ct_next;
        end
    end

endmodule

// File: tb/tb_lwe_encrypt_accum.sv
// Directed self-checking bench for lwe_encrypt_accum with default parameters.
module tb_lwe_encrypt_accum;

    logic        clk;
    logic        rst;
    logic        done;
    logic        en;
    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic [1:0]  row;
    logic [31:0] ciphertext;

    int tests_run    = 0;
    int tests_failed = 0;

    lwe_encrypt_accum dut (
        .clk        (clk),
        .rst_n      (rst),
        .done       (done),
        .en         (en),
        .op1        (op1),
        .op2        (op2),
        .row        (row),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic e, input logic d, input int r,
                         input int a0, input int a1, input int b0, input int b1);
        en     = e;
        done   = d;
        row    = 2'(r);
        op1[0] = 32'(a0);
        op1[1] = 32'(a1);
        op2[0] = 32'(b0);
        op2[1] = 32'(b1);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_eq("reset", ciphertext, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("after_release", ciphertext, 32'd0);

        // Row 0: P=48 then P=7.
        drive(1'b1, 1'b0, 0, 25, 5, 13, 5);
        tick();
        check_eq("first_enable_no_publish", ciphertext, 32'd0);
        drive(1'b1, 1'b0, 0, 2, 0, 5, 0);
        tick();
        check_eq("same_row_no_publish", ciphertext, 32'd0);
        // Row 1: P=22, publishes 55.
        drive(1'b1, 1'b0, 1, 12, 2, 5, 3);
        tick();
        check_eq("row_change_publish", ciphertext, 32'd55);
        // Row 2: publishes 22, then holds while row stays 2.
        drive(1'b1, 1'b0, 2, 12, 2, 5, 3);
        tick();
        check_eq("publish_row1", ciphertext, 32'd22);
        tick();
        check_eq("hold_same_row", ciphertext, 32'd22);
        // Row 0 with wrap: P=1030 mod 1024 = 6, twice; publishes row 2 = 44.
        drive(1'b1, 1'b0, 0, 1000, 20, 10, 0);
        tick();
        check_eq("publish_row2", ciphertext, 32'd44);
        tick();
        // Row 1 with P=40: publishes 12.
        drive(1'b1, 1'b0, 1, 30, 2, 5, 3);
        tick();
        check_eq("wrap_publish", ciphertext, 32'd12);
        tick();
        // done with en=0 flushes 80.
        drive(1'b0, 1'b1, 1, 0, 0, 0, 0);
        tick();
        check_eq("done_flush", ciphertext, 32'd80);
        // Fresh start on row 2, no spurious publish.
        drive(1'b1, 1'b0, 2, 12, 2, 5, 3);
        tick();
        check_eq("fresh_after_done", ciphertext, 32'd80);
        // Oversized lanes: 2053+1024+3+1025 = 4105 -> 9, acc = 31.
        drive(1'b1, 1'b0, 2, 2053, 1024, 3, 1025);
        tick();
        check_eq("big_lanes_no_publish", ciphertext, 32'd80);
        // Row 3 (beyond DIMENSION) accepted, publishes 31.
        drive(1'b1, 1'b0, 3, 0, 0, 0, 0);
        tick();
        check_eq("big_lanes_reduced", ciphertext, 32'd31);
        // en=0 with a changing row and lanes: nothing moves.
        drive(1'b0, 1'b0, 1, 77, 88, 99, 11);
        tick();
        check_eq("en_gated", ciphertext, 32'd31);
        drive(1'b1, 1'b0, 3, 10, 0, 0, 0);
        tick();
        check_eq("en_resume_same_row", ciphertext, 32'd31);
        drive(1'b1, 1'b0, 3, 5, 0, 0, 0);
        tick();
        check_eq("pre_async_reset", ciphertext, 32'd31);
        // Async reset between edges.
        #1 rst = 1'b1;
        #1 check_eq("async_reset", ciphertext, 32'd0);
        drive(1'b0, 1'b0, 3, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        // Partial total 15 must be gone: new row 3 total is just 7.
        drive(1'b1, 1'b0, 3, 7, 0, 0, 0);
        tick();
        check_eq("post_reset_first", ciphertext, 32'd0);
        drive(1'b1, 1'b0, 0, 25, 5, 13, 5);
        tick();
        check_eq("partial_discarded", ciphertext, 32'd7);
        // done with en=1 on the same row: 48 + 7.
        drive(1'b1, 1'b1, 0, 2, 0, 5, 0);
        tick();
        check_eq("done_en_same_row", ciphertext, 32'd55);
        drive(1'b1, 1'b0, 1, 12, 2, 5, 3);
        tick();
        check_eq("fresh_after_done_en", ciphertext, 32'd55);
        // done with en=1 on a new row: publish acc only (22), open row 2.
        drive(1'b1, 1'b1, 2, 12, 2, 5, 3);
        tick();
        check_eq("done_en_row_change", ciphertext, 32'd22);
        drive(1'b1, 1'b0, 2, 7, 0, 0, 0);
        tick();
        check_eq("row_opened_by_done", ciphertext, 32'd22);
        drive(1'b0, 1'b1, 2, 0, 0, 0, 0);
        tick();
        check_eq("done_flush_29", ciphertext, 32'd29);
        // done while idle publishes zero.
        tick();
        check_eq("done_idle_zero", ciphertext, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lwe_encrypt_accum.md
Name: lwe_encrypt_accum

Overview:
- Streaming row accumulator for the LWE encryption datapath.
- Each enabled cycle it sums 2×PARALLEL operand lanes into a running per-row total, modulo CIPHERTEXT_MODULUS.
- When the row index changes, or `done` is pulsed, the finished row total is published on `ciphertext`.
- It sits between the operand-fetch stage (key/randomness lanes) and the ciphertext output buffer.

Parameters:
- PLAINTEXT_MODULUS, 64: plaintext modulus; carried for interface uniformity, not used in arithmetic.
- PLAINTEXT_WIDTH, 6: log2(PLAINTEXT_MODULUS); not used in arithmetic.
- CIPHERTEXT_MODULUS, 1024: modulus for all accumulation; must be a power of two ≤ 2^CIPHERTEXT_WIDTH.
- CIPHERTEXT_WIDTH, 32: width of operand lanes and of `ciphertext`.
- DIMENSION, 3: number of rows.
- DIM_WIDTH, 2: width of `row`.
- BIG_N, 2: number of samples; not used in arithmetic.
- PARALLEL, 2: lanes per operand array.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-high (asserted while 1, despite the name).
- done  in  1  flush pulse: publish the current row total.
- en  in  1  accumulate this cycle's lanes.
- op1  in  PARALLEL×CIPHERTEXT_WIDTH (unpacked array)  operand lanes A.
- op2  in  PARALLEL×CIPHERTEXT_WIDTH (unpacked array)  operand lanes B.
- row  in  DIM_WIDTH  row index of this cycle's operands.
- ciphertext  out  CIPHERTEXT_WIDTH  registered total of the most recently completed row.

Behaviour:
- Reset (rst_n=1, async):
  - acc=0, last_row=0, started=0, ciphertext=0.
  - Reset mid-row discards the partial total.
- Per-cycle partial: P = (Σ_i op1[i] + Σ_i op2[i]) mod CIPHERTEXT_MODULUS.
  - Full-width adder tree; reduce by masking to log2(CIPHERTEXT_MODULUS) bits.
- On each rising edge with en=1:
  - started=0: acc←P, last_row←row, started←1, ciphertext unchanged.
  - started=1 and row==last_row: acc←(acc+P) mod CIPHERTEXT_MODULUS.
  - started=1 and row!=last_row: ciphertext←acc, acc←P, last_row←row.
- en=0: acc, last_row and ciphertext hold. A row change while en=0 has no effect until the next enabled cycle.
- done=1 (priority over the row-change publish):
  - ciphertext←acc, plus P if en=1 and row==last_row.
  - If en=1 and row!=last_row: ciphertext←acc only, then acc←P, last_row←row.
  - Otherwise acc←0, started←0.
  - done with started=0 and en=0: ciphertext←0.
- Latency: a row total appears on `ciphertext` one clock after the first enabled cycle of the next row (or the `done` edge). It holds until the next publish.
- Wrap-around: acc and ciphertext never exceed CIPHERTEXT_MODULUS-1. Upper bits of `ciphertext` above log2(modulus) are always 0.
- Row index values ≥ DIMENSION are accepted and treated as ordinary row indices; no error output.

Decomposition:
- Shared package `lwe_pkg`:
  - default parameter constants (moduli, widths, DIMENSION, PARALLEL);
  - a mod-reduce function (mask to log2 modulus).
- One natural sub-module: `lane_sum`, a combinational adder tree over 2×PARALLEL lanes producing P. The accumulator/row-tracking FSM stays in the top.

Test Plan:
- Reset: hold rst_n=1 for two cycles with en=0 → ciphertext=0. Release (rst_n=0); ciphertext stays 0.
- Row accumulate and publish:
  - row=0, en=1, op1={25,5}, op2={13,5} (P=48) for one cycle, then op1={2,0}, op2={5,0} (P=7).
  - Then row=1, op1={12,2}, op2={5,3} (P=22).
  - One clock later ciphertext=55.
- Repeated rows:
  - Continue with row=2, same lanes (P=22) → one clock later ciphertext=22.
  - ciphertext holds 22 while row stays 2.
- Modulus wrap:
  - row=0, op1={1000,20}, op2={10,0} (P=1030 mod 1024=6), then next cycle also P=1030, then change row → ciphertext=12.
  - Lane values ≥1024 are reduced.
- done flush:
  - row=1, en=1, P=40 for two cycles (accumulating 80), then en=0 and a one-cycle done pulse → ciphertext=80.
  - The next enabled cycle starts fresh with no spurious publish.
- en gating and async reset:
  - en=0 with changing row/lanes → no change to ciphertext.
  - Assert rst_n=1 mid-row → ciphertext=0 immediately, without waiting for a clock edge. Prior partial total discarded.
